// File: rtl/feature_burst_loader.sv
`default_nettype none
// ============================================================================
//  Module      : feature_burst_loader
//  Description : Upstream stage of the ping-pong tree-ensemble accelerator.
//                Takes one burst config (sample count), then a 32-bit feature
//                stream with valid/ready. Feature pairs are packed into 64-bit
//                words and written into the engine's feature memory. After the
//                final write the engine is started. When the engine reports
//                done, completion is signalled upstream.
//  Ports       : clk, rst (sync, active-high)
//                cfg_valid/cfg_ready/cfg_burst_len   burst config handshake
//                s_valid/s_ready/s_data/s_last       feature stream
//                load_features/feature_addr/features2 feature memory write
//                burst_len, eng_start, eng_done      engine interface
//                busy, done, err_len, err_frame      status
//  Revision    : 1.0  initial release
// ============================================================================
module feature_burst_loader #(
    parameter int N_FEATURE   = 32,
    parameter int MAX_BURST   = 5000,
    localparam int c_LEN_W    = $clog2(MAX_BURST) + 1,
    localparam int c_ADDR_W   = $clog2(MAX_BURST * N_FEATURE / 2)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [c_LEN_W-1:0]  cfg_burst_len,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [31:0]         s_data,
    input  logic                s_last,
    output logic                load_features,
    output logic [c_ADDR_W-1:0] feature_addr,
    output logic [63:0]         features2,
    output logic [c_LEN_W-1:0]  burst_len,
    output logic                eng_start,
    input  logic                eng_done,
    output logic                busy,
    output logic                done,
    output logic                err_len,
    output logic                err_frame
);

    // Wide enough to hold burst_len * N_FEATURE/2 without truncation.
    localparam int c_PROD_W = c_LEN_W + $clog2(N_FEATURE / 2) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_START = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_phase;       // 0: expecting even feature, 1: odd
    logic [31:0]           r_holder;      // even feature awaiting its partner
    logic [c_ADDR_W-1:0]   r_wcnt;        // next word address to be written
    logic [c_ADDR_W-1:0]   r_last_word;   // address of the final word of the burst
    logic                  r_load;
    logic [c_ADDR_W-1:0]   r_addr;
    logic [63:0]           r_features2;
    logic [c_LEN_W-1:0]    r_burst_len;
    logic                  r_eng_start;
    logic                  r_done;
    logic                  r_err_len;
    logic                  r_err_frame;

    logic                  w_len_ok;
    logic [c_PROD_W-1:0]   w_total_words;
    logic [c_ADDR_W-1:0]   w_last_word;
    logic                  w_final_beat;

    assign w_len_ok      = (cfg_burst_len != '0) &&
                           (cfg_burst_len <= c_LEN_W'(MAX_BURST));
    assign w_total_words = c_PROD_W'(cfg_burst_len) * c_PROD_W'(N_FEATURE / 2);
    // Only used when the length is valid, so total >= 1 and the result fits.
    assign w_last_word   = c_ADDR_W'(w_total_words - c_PROD_W'(1));
    // The final beat is the odd half of the final word.
    assign w_final_beat  = r_phase && (r_wcnt == r_last_word);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_phase     <= 1'b0;
            r_holder    <= '0;
            r_wcnt      <= '0;
            r_last_word <= '0;
            r_load      <= 1'b0;
            r_addr      <= '0;
            r_features2 <= '0;
            r_burst_len <= '0;
            r_eng_start <= 1'b0;
            r_done      <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_frame <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            r_load      <= 1'b0;
            r_eng_start <= 1'b0;
            r_done      <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_frame <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        if (!w_len_ok) begin
                            r_err_len <= 1'b1;
                        end else begin
                            r_burst_len <= cfg_burst_len;
                            r_last_word <= w_last_word;
                            r_wcnt      <= '0;
                            r_phase     <= 1'b0;
                            r_state     <= S_LOAD;
                        end
                    end
                end

                S_LOAD: begin
                    if (s_valid) begin
                        // s_last is only checked; the word count decides the end.
                        r_err_frame <= (s_last != w_final_beat);
                        if (!r_phase) begin
                            r_holder <= s_data;
                            r_phase  <= 1'b1;
                        end else begin
                            r_load      <= 1'b1;
                            r_features2 <= {s_data, r_holder};
                            r_addr      <= r_wcnt;
                            r_phase     <= 1'b0;
                            // Counter stops on the last word so the address never wraps.
                            if (w_final_beat) begin
                                r_state <= S_START;
                            end else begin
                                r_wcnt <= r_wcnt + 1'b1;
                            end
                        end
                    end
                end

                // The final write strobe is on the outputs during this state.
                S_START: begin
                    r_eng_start <= 1'b1;
                    r_state     <= S_RUN;
                end

                S_RUN: begin
                    if (eng_done) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cfg_ready     = (r_state == S_IDLE);
    assign s_ready       = (r_state == S_LOAD);
    assign busy          = (r_state != S_IDLE);
    assign load_features = r_load;
    assign feature_addr  = r_addr;
    assign features2     = r_features2;
    assign burst_len     = r_burst_len;
    assign eng_start     = r_eng_start;
    assign done          = r_done;
    assign err_len       = r_err_len;
    assign err_frame     = r_err_frame;

endmodule
`default_nettype wire
